// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between issue logic and the multiply/divide unit.
// Master drives the request; slave returns status, result and register-file write-back.
interface muldiv_unit_if #(
    parameter int dw = 32,
    parameter int aw = 5
);
    logic          start;
    logic [1:0]    op;
    logic [dw-1:0] src_a;
    logic [dw-1:0] src_b;
    logic [aw-1:0] dest_addr;
    logic          busy;
    logic          done;
    logic [dw-1:0] hi;
    logic [dw-1:0] lo;
    logic          wb_write;
    logic [aw-1:0] wb_addr;
    logic [dw-1:0] wb_data;

    modport master (
        output start, op, src_a, src_b, dest_addr,
        input  busy, done, hi, lo, wb_write, wb_addr, wb_data
    );

    modport slave (
        input  start, op, src_a, src_b, dest_addr,
        output busy, done, hi, lo, wb_write, wb_addr, wb_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned shift-add multiply / restoring divide, one bit per cycle.
// Divide (op 2'b01) is present only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
    parameter int dw = 32,
    parameter int aw = 5
) (
    input  logic clk,
    input  logic rst_n,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] LAST = 6'(dw - 1);

    state_t        state_q;
    logic [5:0]    cnt_q;
    logic [dw-1:0] a_q;
    logic [dw-1:0] acc_q;
    logic [dw-1:0] mq_q;
    logic [aw-1:0] dest_q;
    logic          busy_q;
    logic          done_q;
    logic [dw-1:0] hi_q;
    logic [dw-1:0] lo_q;
    logic          wb_write_q;
    logic [aw-1:0] wb_addr_q;
    logic [dw-1:0] wb_data_q;

    logic [dw-1:0] addend;
    logic [dw:0]   mul_sum;
    logic [dw-1:0] acc_d;
    logic [dw-1:0] mq_d;
    logic          start_ok;
    logic          wb_en;

`ifdef MULDIV_DIV_EN
    logic          op_q;
    logic [dw-1:0] b_q;
    logic [dw:0]   div_shift;
    logic [dw:0]   div_diff;

    assign start_ok = bus.start && (bus.op == 2'b00 || bus.op == 2'b01);
`else
    assign start_ok = bus.start && bus.op == 2'b00;
`endif

    assign wb_en = |dest_q;

    // acc holds the running upper half (multiply) or partial remainder (divide);
    // mq holds the multiplier being consumed or the quotient being formed.
    always_comb begin
        addend  = mq_q[0] ? a_q : '0;
        mul_sum = {1'b0, acc_q} + {1'b0, addend};
        acc_d   = mul_sum[dw:1];
        mq_d    = {mul_sum[0], mq_q[dw-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {acc_q, mq_q[dw-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (op_q) begin
            acc_d = div_diff[dw] ? div_shift[dw-1:0] : div_diff[dw-1:0];
            mq_d  = {mq_q[dw-2:0], ~div_diff[dw]};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            dest_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            wb_write_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
`ifdef MULDIV_DIV_EN
            op_q       <= 1'b0;
            b_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q     <= 1'b0;
                    wb_write_q <= 1'b0;
                    wb_addr_q  <= '0;
                    wb_data_q  <= '0;
                    if (start_ok) begin
                        a_q     <= bus.src_a;
                        mq_q    <= bus.src_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        dest_q  <= bus.dest_addr;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef MULDIV_DIV_EN
                        op_q    <= bus.op[0];
                        b_q     <= bus.src_b;
                        if (bus.op[0]) begin
                            mq_q <= bus.src_a;
                            // Zero divisor: skip iteration, result is fixed.
                            if (bus.src_b == '0) begin
                                state_q    <= DONE;
                                done_q     <= 1'b1;
                                lo_q       <= '1;
                                hi_q       <= bus.src_a;
                                wb_write_q <= |bus.dest_addr;
                                wb_addr_q  <= bus.dest_addr;
                                wb_data_q  <= (|bus.dest_addr) ? '1 : '0;
                            end
                        end
`endif
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    mq_q  <= mq_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        hi_q       <= acc_d;
                        lo_q       <= mq_d;
                        wb_write_q <= wb_en;
                        wb_addr_q  <= dest_q;
                        wb_data_q  <= wb_en ? mq_d : '0;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    wb_write_q <= 1'b0;
                    wb_addr_q  <= '0;
                    wb_data_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.wb_write = wb_write_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
endmodule
